fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 7 +
 rtl/pc_register.sv | 19 +
 rtl/fetch_stage.sv | 78 +++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} fetch_state_e;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD        = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'hE1A0_0000;
endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with sync reset, advance enable and word-aligned redirect load
module pc_register #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    output logic [31:0] pc_o
);
    logic [31:0] pc_q, pc_d;
    always_comb pc_d = !en_i ? pc_q : load_i ? {load_pc_i[31:2], 2'b00} : pc_q + 32'd4;
    always_ff @(posedge clk) begin
        if (reset) pc_q <= RESET_VAL;
        else       pc_q <= pc_d;
    end
    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-slot instruction fetch with BOOT/RUN/HALT control and decode handshake
module fetch_stage import fetch_pkg::*; #(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter bit          HALT_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus8_d,
    output logic        valid_d,
    input  logic        ready_d,
    output logic        halted,
    output logic [31:0] fetch_count
);
    fetch_state_e state_q;
    logic [31:0] pc, instr_q, pcd_q, pc8_q, count_q;
    logic valid_q, halted_q, stall, halt_word, take_redirect, issue;
    always_comb begin
        stall         = valid_q && !ready_d;
        halt_word     = HALT_EN && (imem_rd == HALT_WORD);
        take_redirect = redirect && (state_q != ST_BOOT);
        issue         = (state_q == ST_RUN) && !redirect && !stall && !halt_word;
    end
    pc_register #(.RESET_VAL(RESET_VECTOR)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .en_i     (take_redirect || issue),
        .load_i   (take_redirect),
        .load_pc_i(redirect_pc),
        .pc_o     (pc)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_BOOT;
            valid_q  <= 1'b0;
            instr_q  <= 32'h0;
            pcd_q    <= 32'h0;
            pc8_q    <= 32'h0;
            halted_q <= 1'b0;
            count_q  <= 32'h0;
        end else begin
            if (valid_q && ready_d && count_q != 32'hFFFF_FFFF) count_q <= count_q + 32'd1;
            if (take_redirect) begin
                state_q  <= ST_RUN;
                valid_q  <= 1'b0;
                halted_q <= 1'b0;
            end else if (state_q == ST_BOOT) begin
                state_q <= ST_RUN;
            end else if (!stall) begin
                if (issue) begin
                    instr_q <= imem_rd;
                    pcd_q   <= pc;
                    pc8_q   <= pc + 32'd8;
                    valid_q <= 1'b1;
                end else begin
                    // slot drained with nothing new: either already halted or just fetched the halt word
                    valid_q <= 1'b0;
                    if (state_q == ST_RUN) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end
                end
            end
        end
    end
    assign imem_a      = pc;
    assign instr_d     = instr_q;
    assign pc_d        = pcd_q;
    assign pc_plus8_d  = pc8_q;
    assign valid_d     = valid_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
    logic        clk = 1'b0, reset = 1'b1, redirect = 1'b0, ready_d = 1'b1;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_a, imem_rd, instr_d, pc_d, pc_plus8_d, fetch_count;
    logic        valid_d, halted;
    int          tests = 0, fails = 0;
    logic [31:0] mem [64];
    logic [31:0] m_pc, m_instr, m_pcd, m_pc8, m_cnt;
    logic        m_valid;
    int          m_mode;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a < 32'h100) ? mem[a[7:2]] : ({a[31:2], 2'b01} ^ 32'h1357_0000);
    endfunction

    assign imem_rd = rom(imem_a);

    fetch_stage dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_d(instr_d),
        .pc_d(pc_d), .pc_plus8_d(pc_plus8_d), .valid_d(valid_d), .ready_d(ready_d),
        .halted(halted), .fetch_count(fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference: mode 0 boot, 1 run, 2 halt
    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_mode = 0; m_valid = 1'b0;
            m_instr = 32'h0; m_pcd = 32'h0; m_pc8 = 32'h0; m_cnt = 32'h0;
        end else begin
            if (m_valid && ready_d && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_mode != 0 && redirect) begin
                m_pc = redirect_pc & ~32'd3; m_valid = 1'b0; m_mode = 1;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (!(m_valid && !ready_d)) begin
                if (m_mode == 2) m_valid = 1'b0;
                else if (rom(m_pc) == 32'h0) begin m_mode = 2; m_valid = 1'b0; end
                else begin
                    m_instr = rom(m_pc); m_pcd = m_pc; m_pc8 = m_pc + 8;
                    m_valid = 1'b1; m_pc = m_pc + 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_a", imem_a, m_pc);
            check("valid_d", 32'(valid_d), 32'(m_valid));
            check("instr_d", instr_d, m_instr);
            check("pc_d", pc_d, m_pcd);
            check("pc_plus8_d", pc_plus8_d, m_pc8);
            check("halted", 32'(halted), 32'(m_mode == 2));
            check("fetch_count", fetch_count, m_cnt);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(valid_d), 32'h0);
        check({tag, "_instr"}, instr_d, 32'h0);
        check({tag, "_pc_d"}, pc_d, 32'h0);
        check({tag, "_pc8"}, pc_plus8_d, 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_count"}, fetch_count, 32'h0);
        check({tag, "_imem_a"}, imem_a, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hE3A0_0000 | 32'(i);
        mem[0] = 32'hE59F_0068; mem[1] = 32'hE59F_1068; mem[2] = 32'hE59F_2064;
        mem[29] = 32'h0; mem[45] = 32'h0;
        tick;
        chk_en = 1'b1;
        tick;
        check_reset_vals("por");
        // release with a redirect during BOOT, which must be ignored
        reset = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
        tick;
        redirect = 1'b0;
        check("boot_imem_a", imem_a, 32'h0);
        check("boot_valid", 32'(valid_d), 32'h0);
        tick;
        check("f0_valid", 32'(valid_d), 32'h1);
        check("f0_pc", pc_d, 32'h0);
        check("f0_instr", instr_d, 32'hE59F_0068);
        check("f0_pc8", pc_plus8_d, 32'h8);
        tick;
        check("f1_pc", pc_d, 32'h4);
        check("f1_instr", instr_d, 32'hE59F_1068);
        check("f1_pc8", pc_plus8_d, 32'hC);
        check("f1_count", fetch_count, 32'h1);
        ready_d = 1'b0;
        repeat (3) begin
            tick;
            check("stall_pc", pc_d, 32'h4);
            check("stall_instr", instr_d, 32'hE59F_1068);
            check("stall_imem_a", imem_a, 32'h8);
            check("stall_count", fetch_count, 32'h1);
        end
        ready_d = 1'b1;
        tick;
        check("f2_pc", pc_d, 32'h8);
        check("f2_instr", instr_d, 32'hE59F_2064);
        check("f2_pc8", pc_plus8_d, 32'h10);
        check("f2_count", fetch_count, 32'h2);
        // redirect beats stall
        ready_d = 1'b0; redirect = 1'b1; redirect_pc = 32'h52;
        tick;
        redirect = 1'b0;
        check("redir_valid", 32'(valid_d), 32'h0);
        check("redir_imem_a", imem_a, 32'h50);
        ready_d = 1'b1;
        tick;
        check("redir_pc", pc_d, 32'h50);
        // halt on zero word at 0x74
        redirect = 1'b1; redirect_pc = 32'h68;
        tick;
        redirect = 1'b0;
        repeat (3) tick;
        check("pre_halt_pc", pc_d, 32'h70);
        tick;
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_valid", 32'(valid_d), 32'h0);
        repeat (2) tick;
        check("halt_hold_valid", 32'(valid_d), 32'h0);
        check("halt_hold_imem_a", imem_a, 32'h74);
        redirect = 1'b1; redirect_pc = 32'h0;
        tick;
        redirect = 1'b0;
        check("unhalt_halted", 32'(halted), 32'h0);
        tick;
        check("unhalt_pc", pc_d, 32'h0);
        check("unhalt_valid", 32'(valid_d), 32'h1);
        // reset during HALT, with a competing redirect
        redirect = 1'b1; redirect_pc = 32'h70;
        tick;
        redirect = 1'b0;
        repeat (2) tick;
        check("halt2_halted", 32'(halted), 32'h1);
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
        tick;
        redirect = 1'b0;
        check_reset_vals("rst_halt");
        // reset during stall
        reset = 1'b0;
        repeat (2) tick;
        ready_d = 1'b0;
        repeat (2) tick;
        check("stall2_valid", 32'(valid_d), 32'h1);
        reset = 1'b1;
        tick;
        check_reset_vals("rst_stall");
        reset = 1'b0; ready_d = 1'b1;
        repeat (2) tick;
        // PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick;
        redirect = 1'b0;
        tick;
        check("wrap0_pc", pc_d, 32'hFFFF_FFF8);
        check("wrap0_pc8", pc_plus8_d, 32'h0);
        tick;
        check("wrap1_pc", pc_d, 32'hFFFF_FFFC);
        check("wrap1_pc8", pc_plus8_d, 32'h4);
        tick;
        check("wrap2_pc", pc_d, 32'h0);
        check("wrap2_pc8", pc_plus8_d, 32'h8);
        check("wrap2_instr", instr_d, 32'hE59F_0068);
        // randomized traffic
        repeat (3000) begin
            ready_d     = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                      : $urandom_range(0, 255);
            reset       = ($urandom_range(0, 199) == 0);
            tick;
        end
        reset = 1'b0; redirect = 1'b0;
        tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
